// File: rtl/hamming_decoder.sv
// Byte-serial SECDED decoder for Hamming(15,11) plus overall parity.
// Accepts a codeword as two bytes, then returns two corrected data bytes with a status code.
module hamming_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [7:0]       IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [7:0]       OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [1:0]       STATUS,
  output logic [CNT_W-1:0] CORR_CNT,
  output logic [CNT_W-1:0] UNCORR_CNT
);

  typedef enum logic [2:0] {
    RX_LO  = 3'd0,
    RX_HI  = 3'd1,
    DECODE = 3'd2,
    TX_LO  = 3'd3,
    TX_HI  = 3'd4
  } state_t;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;

  state_t           r_state;
  logic [15:0]      r_code;
  logic [2:0]       r_data_hi;
  logic [7:0]       r_out_data;
  logic [1:0]       r_status;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;

  logic [3:0]  w_syn;
  logic        w_par;
  logic [15:0] w_fixed;
  logic [7:0]  w_lo;
  logic [2:0]  w_hi;
  logic [1:0]  w_status;

  always_comb begin
    w_syn = '0;
    for (int unsigned i = 1; i < 16; i++) begin
      if (r_code[i]) w_syn = w_syn ^ 4'(i);
    end
    w_par = ^r_code;
    // A syndrome of zero with odd parity lands on c[0], leaving the data bits untouched.
    w_fixed = r_code;
    if (w_par) w_fixed[w_syn] = ~r_code[w_syn];
    w_lo = {w_fixed[12], w_fixed[11], w_fixed[10], w_fixed[9],
            w_fixed[7],  w_fixed[6],  w_fixed[5],  w_fixed[3]};
    w_hi = w_fixed[15:13];
    if (w_par)              w_status = ST_CORR;
    else if (w_syn != 4'd0) w_status = ST_UNCORR;
    else                    w_status = ST_CLEAN;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state      <= RX_LO;
      r_code       <= '0;
      r_data_hi    <= '0;
      r_out_data   <= '0;
      r_status     <= ST_CLEAN;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      case (r_state)
        RX_LO: if (IN_VALID) begin
          r_code[7:0] <= IN_DATA;
          r_state     <= RX_HI;
        end
        RX_HI: if (IN_VALID) begin
          r_code[15:8] <= IN_DATA;
          r_in_ready   <= 1'b0;
          r_state      <= DECODE;
        end
        DECODE: begin
          r_out_data  <= w_lo;
          r_data_hi   <= w_hi;
          r_status    <= w_status;
          r_out_valid <= 1'b1;
          if (w_status == ST_CORR && r_corr_cnt != '1)
            r_corr_cnt <= r_corr_cnt + 1'b1;
          if (w_status == ST_UNCORR && r_uncorr_cnt != '1)
            r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
          r_state <= TX_LO;
        end
        TX_LO: if (OUT_READY) begin
          r_out_data <= {5'b0, r_data_hi};
          r_state    <= TX_HI;
        end
        TX_HI: if (OUT_READY) begin
          r_out_data  <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= RX_LO;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= RX_LO;
        end
      endcase
    end
  end

  assign IN_READY   = r_in_ready;
  assign OUT_VALID  = r_out_valid;
  assign OUT_DATA   = r_out_data;
  assign STATUS     = r_status;
  assign CORR_CNT   = r_corr_cnt;
  assign UNCORR_CNT = r_uncorr_cnt;

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: hand-computed codewords, handshake timing,
// backpressure, input gaps, mid-word reset and counter saturation.
module tb_hamming_decoder;

  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             Reset = 1'b1;
  logic [7:0]       IN_DATA = '0;
  logic             IN_VALID = 1'b0;
  logic             IN_READY;
  logic [7:0]       OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY = 1'b0;
  logic [1:0]       STATUS;
  logic [CNT_W-1:0] CORR_CNT;
  logic [CNT_W-1:0] UNCORR_CNT;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_corr = 0;
  int exp_uncorr = 0;

  hamming_decoder #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .STATUS(STATUS), .CORR_CNT(CORR_CNT), .UNCORR_CNT(UNCORR_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offers one byte; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input string tag);
    int n;
    IN_DATA  = b;
    IN_VALID = 1'b1;
    n = 0;
    while (!IN_READY && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_in_ready"}, IN_READY, 1);
    tick();
    IN_VALID = 1'b0;
    IN_DATA  = 8'hA5;
  endtask

  task automatic recv_word(input logic [7:0] lo, input logic [7:0] hi,
                           input logic [1:0] st, input string tag);
    int n;
    OUT_READY = 1'b1;
    n = 0;
    while (!OUT_VALID && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid_lo"}, OUT_VALID, 1);
    check({tag, "_lo"}, OUT_DATA, lo);
    check({tag, "_status_lo"}, STATUS, st);
    check({tag, "_in_ready_lo"}, IN_READY, 0);
    tick();
    check({tag, "_valid_hi"}, OUT_VALID, 1);
    check({tag, "_hi"}, OUT_DATA, hi);
    check({tag, "_status_hi"}, STATUS, st);
    tick();
    OUT_READY = 1'b0;
    check({tag, "_valid_done"}, OUT_VALID, 0);
    check({tag, "_in_ready_done"}, IN_READY, 1);
    check({tag, "_corr_cnt"}, CORR_CNT, exp_corr);
    check({tag, "_uncorr_cnt"}, UNCORR_CNT, exp_uncorr);
  endtask

  task automatic word(input logic [7:0] c_lo, input logic [7:0] c_hi,
                      input logic [7:0] lo, input logic [7:0] hi,
                      input logic [1:0] st, input string tag);
    send_byte(c_lo, tag);
    send_byte(c_hi, tag);
    if (st == 2'b01 && exp_corr < 255) exp_corr++;
    if (st == 2'b10 && exp_uncorr < 255) exp_uncorr++;
    recv_word(lo, hi, st, tag);
  endtask

  initial begin
    tick(); tick();
    Reset = 1'b0;
    check("rst_in_ready", IN_READY, 1);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_data", OUT_DATA, 0);
    check("rst_status", STATUS, 0);
    check("rst_corr", CORR_CNT, 0);
    check("rst_uncorr", UNCORR_CNT, 0);

    // Clean word with latency check: high byte accepted at edge k, valid after edge k+1.
    send_byte(8'h0F, "lat");
    send_byte(8'h00, "lat");
    check("lat_decode_valid", OUT_VALID, 0);
    check("lat_decode_in_ready", IN_READY, 0);
    tick();
    check("lat_tx_valid", OUT_VALID, 1);
    recv_word(8'h01, 8'h00, 2'b00, "clean");

    word(8'h2F, 8'h00, 8'h01, 8'h00, 2'b01, "single_c5");
    word(8'h0E, 8'h00, 8'h01, 8'h00, 2'b01, "p0_only");
    word(8'h6F, 8'h00, 8'h07, 8'h00, 2'b10, "double_c5c6");
    word(8'hFF, 8'hFF, 8'hFF, 8'h07, 2'b00, "all_ones");
    word(8'hFF, 8'hDF, 8'hFF, 8'h07, 2'b01, "single_c13");
    word(8'hFF, 8'hBD, 8'hEF, 8'h05, 2'b10, "double_c9c14");

    // Backpressure in TX_LO.
    send_byte(8'h2F, "bp");
    send_byte(8'h00, "bp");
    exp_corr++;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", OUT_VALID, 1);
      check("bp_data", OUT_DATA, 8'h01);
      check("bp_status", STATUS, 2'b01);
      check("bp_in_ready", IN_READY, 0);
      tick();
    end
    recv_word(8'h01, 8'h00, 2'b01, "bp");

    // Idle gaps with garbage on IN_DATA between bytes.
    send_byte(8'h0F, "gap");
    IN_DATA = 8'hFF;
    for (int i = 0; i < 4; i++) tick();
    check("gap_no_output", OUT_VALID, 0);
    send_byte(8'h00, "gap");
    recv_word(8'h01, 8'h00, 2'b00, "gap");

    // Reset after low byte, with a simultaneous offered byte that must be ignored.
    send_byte(8'h6F, "mid_rst");
    Reset = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA = 8'hAA;
    tick();
    Reset = 1'b0;
    IN_VALID = 1'b0;
    exp_corr = 0;
    exp_uncorr = 0;
    check("mid_rst_in_ready", IN_READY, 1);
    check("mid_rst_valid", OUT_VALID, 0);
    check("mid_rst_corr", CORR_CNT, 0);
    check("mid_rst_uncorr", UNCORR_CNT, 0);
    word(8'h0F, 8'h00, 8'h01, 8'h00, 2'b00, "post_rst");

    // Reset while holding output in TX_LO.
    send_byte(8'h6F, "tx_rst");
    send_byte(8'h00, "tx_rst");
    tick();
    check("tx_rst_pre_valid", OUT_VALID, 1);
    Reset = 1'b1;
    OUT_READY = 1'b1;
    tick();
    Reset = 1'b0;
    OUT_READY = 1'b0;
    check("tx_rst_valid", OUT_VALID, 0);
    check("tx_rst_data", OUT_DATA, 0);
    check("tx_rst_status", STATUS, 0);
    check("tx_rst_uncorr", UNCORR_CNT, 0);

    // Saturation: 300 single-error words.
    for (int i = 0; i < 300; i++) word(8'h2F, 8'h00, 8'h01, 8'h00, 2'b01, "sat");
    check("sat_corr_final", CORR_CNT, 255);
    check("sat_uncorr_final", UNCORR_CNT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_decoder.md
Name: hamming_decoder

Overview:
- Byte-serial SECDED decoder. It receives 16-bit Hamming(15,11)+overall-parity codewords over the 8-bit datapath, corrects single-bit errors, flags double-bit errors, and returns the 11 data bits as two bytes plus a status code.
- It is the receive/check end of the parity path whose encode side is the processor's ALU parity (countOnes) output.
- It sits between data memory readout and the result-writeback stage.

Parameters:
CNT_W, 8, width of the saturating corrected-word and uncorrectable-word counters

Ports:
CLK  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
IN_DATA  input  8  codeword byte; low byte first, then high byte
IN_VALID  input  1  IN_DATA valid
IN_READY  output  1  decoder can accept a byte
OUT_DATA  output  8  decoded byte; low byte first, then high byte
OUT_VALID  output  1  OUT_DATA valid
OUT_READY  input  1  consumer accepts OUT_DATA
STATUS  output  2  00 clean, 01 single error corrected, 10 double error (uncorrectable); held for both output bytes
CORR_CNT  output  CNT_W  count of words with STATUS=01, saturating
UNCORR_CNT  output  CNT_W  count of words with STATUS=10, saturating

Behaviour:
- Codeword layout, c[15:0] with bit index = position:
  - c[0] = overall parity p0; even parity over all 16 bits.
  - c[1], c[2], c[4], c[8] = p1, p2, p4, p8.
  - Data d1..d11 = c[3], c[5], c[6], c[7], c[9..15], in ascending order.
- Byte order: first accepted byte is c[7:0], second is c[15:8].
- Byte transfer: a byte moves on any edge where VALID && READY on that side.
- FSM states: RX_LO, RX_HI, DECODE, TX_LO, TX_HI.
  - RX_LO: IN_READY=1. On accept, store c[7:0] and go to RX_HI.
  - RX_HI: IN_READY=1. On accept, store c[15:8] and go to DECODE.
  - DECODE: one cycle, IN_READY=0, OUT_VALID=0.
    - Compute syndrome S[3:0] = XOR of indices of all set bits 1..15.
    - Compute P = XOR of all 16 bits.
    - Register corrected data and STATUS, update counters, go to TX_LO.
  - TX_LO: OUT_VALID=1, OUT_DATA = d8..d1 (d8 in bit 7). On accept go to TX_HI.
  - TX_HI: OUT_VALID=1, OUT_DATA = {5'b0, d11..d9}. On accept go to RX_LO.
- Decode rules:
  - P=0, S=0: no error; STATUS=00.
  - P=1: single error at position S; flip c[S]. S=0 means p0 itself flipped and data is unchanged. STATUS=01, CORR_CNT+1.
  - P=0, S!=0: double error. Data is extracted uncorrected. STATUS=10, UNCORR_CNT+1.
- Latency: high byte accepted at edge k; OUT_VALID asserts in the cycle after edge k+1. Minimum period is 5 cycles per word.
- Input and output never overlap: IN_READY=0 whenever OUT_VALID=1.
- Backpressure: while OUT_VALID=1 and OUT_READY=0, OUT_DATA and STATUS stay stable.
- Counters hold at 2^CNT_W-1 and do not wrap.
- Reset, including mid-word or mid-output:
  - state=RX_LO, IN_READY=1, OUT_VALID=0, OUT_DATA=0, STATUS=00, CORR_CNT=0, UNCORR_CNT=0.
  - Any partial codeword is discarded.
  - Reset has priority over any handshake in the same cycle.
- IN_DATA is ignored when IN_VALID=0. OUT_READY is ignored when OUT_VALID=0.

Test Plan:
- Clean word: send 0x0F, 0x00 (c=0x000F, d1=1) -> OUT bytes 0x01, 0x00, STATUS=00, counters unchanged; OUT_VALID asserts 2 cycles after the high-byte accept edge.
- Single data-bit error: send 0x2F, 0x00 (c[5] flipped; S=5, P=1) -> 0x01, 0x00, STATUS=01, CORR_CNT=1.
- p0-only error: send 0x0E, 0x00 (S=0, P=1) -> 0x01, 0x00, STATUS=01, CORR_CNT increments.
- Double error: send 0x6F, 0x00 (c[5], c[6] flipped; S=3, P=0) -> 0x07, 0x00 uncorrected, STATUS=10, UNCORR_CNT=1.
- Backpressure and gaps:
  - Hold OUT_READY=0 for 10 cycles in TX_LO -> OUT_DATA=0x01 and STATUS stable, IN_READY=0 throughout.
  - Insert IN_VALID=0 gaps between input bytes -> same result.
- Reset and saturation:
  - Assert Reset in RX_HI after the low byte, then send a full 0x0F, 0x00 -> single clean output 0x01, 0x00 with no stale low byte.
  - Send 300 single-error words with CNT_W=8 -> CORR_CNT=255.
